cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the single-cycle datapath around the instruction decoder.
//  Per instruction: fetch -> decode -> execute -> optional memory/writeback.
//  Retires each instruction with one PC advance. Halts on opcode 0; flags a fault on memory timeout.
//  Sits between instruction/data memory handshakes and the PC, IR and register-file enables.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max wait cycles for imem_ready/dmem_ready before FAULT (>=1)
//  CNT_W           32  width of retired-instruction counter
// PORTS
//  clk             in   1      single system clock, rising edge
//  rst_n           in   1      reset, synchronous, active-low
//  start           in   1      leave IDLE and begin fetching (ignored outside IDLE)
//  opcode          in   6      instruction[31:26] of the IR (valid from DECODE onward)
//  imem_ready      in   1      instruction word valid this cycle
//  dmem_ready      in   1      data access complete this cycle
//  branch_cond     in   1      ALU branch result, valid in EXEC
//  imem_req        out  1      instruction fetch request
//  ir_load         out  1      latch instruction register
//  pc_enable       out  1      advance/load PC (one pulse per retired instr)
//  pc_load_branch  out  1      with pc_enable: take branch target instead of PC+1
//  reg_write_en    out  1      register-file write strobe
//  dmem_req        out  1      data memory request
//  dmem_we         out  1      data memory write (store)
//  halted          out  1      in HALT state
//  fault           out  1      in FAULT state (sticky until reset)
//  state           out  3      current FSM state encoding
//  instr_count     out  CNT_W  retired-instruction counter
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; all outputs 0; wait counter 0; instr_count 0.
//  Reset mid-instruction aborts it; no partial enables are issued afterwards.
//  Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 FAULT=7.
//  Opcode classes:
//   - 0      HALT
//   - 1-23   ALU
//   - 24-27  MEMORY; store when opcode[0]=1, load otherwise
//   - 28-63  BRANCH
//  Outputs are Moore decodes of state, except where a _ready term is listed.
//  Transitions:
//   - IDLE: start=1 -> FETCH.
//   - FETCH: imem_req=1. imem_ready=1 -> ir_load=1 same cycle, next DECODE.
//   - DECODE: opcode==0 -> HALT; else -> EXEC.
//   - EXEC, ALU class: -> WB.
//   - EXEC, MEMORY class: -> MEM.
//   - EXEC, BRANCH class: pc_enable=1; pc_load_branch=branch_cond; -> FETCH.
//   - MEM: dmem_req=1; dmem_we=opcode[0]. dmem_ready=1 then:
//       store: pc_enable=1 -> FETCH
//       load:  -> WB
//   - WB: reg_write_en=1, pc_enable=1 -> FETCH.
//   - HALT: halted=1; held until reset (start ignored).
//   - FAULT: fault=1; held until reset.
//  Latency (zero-wait memory):
//   - ALU: 4 cycles
//   - store: 4 cycles
//   - load: 5 cycles
//   - branch: 3 cycles
//   - halt reached 2 cycles after fetch.
//  Wait counter:
//   - Clears on entry to FETCH/MEM; increments each cycle in FETCH/MEM while the _ready input is 0.
//   - Ready arriving on the cycle the count reaches TIMEOUT_CYCLES-1 is still accepted.
//   - Otherwise count == TIMEOUT_CYCLES-1 with ready=0 -> FAULT.
//  instr_count:
//   - +1 on every cycle pc_enable=1; wraps modulo 2^CNT_W.
//   - Value visible the cycle after the pulse.
//  Exactly one pc_enable pulse per non-halt instruction; never in HALT/FAULT/IDLE.
//  reg_write_en and dmem_we are never asserted in the same cycle.
// TESTING
//  1. Reset, start; opcode=5 with ready always 1 -> states 1,2,3,5,1; reg_write_en and pc_enable in WB only; count=1.
//  2. Load opcode=24 with dmem_ready delayed 3 cycles -> dmem_we=0 for 4 MEM cycles, then WB writes; count=1.
//     Store opcode=25 -> dmem_we=1 in MEM, no reg_write_en.
//  3. Branch opcode=30: branch_cond=1 -> pc_enable=pc_load_branch=1 in EXEC.
//     branch_cond=0 -> pc_enable=1, pc_load_branch=0.
//  4. imem_ready held 0 for 16 cycles -> FAULT, fault=1 sticky; ready on 16th cycle -> accepted, no fault.
//  5. opcode=0 -> HALT, halted=1, no pc_enable; start pulses ignored.
//     rst_n=0 during MEM -> next cycle IDLE, all outputs 0, count=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch -> decode -> execute -> mem/writeback,
// driving IR/PC/register-file/data-memory enables and counting retired instructions.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_cond,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_enable,
    output logic             pc_load_branch,
    output logic             reg_write_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int unsigned        WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  count_q;
    logic              is_alu;
    logic              is_branch;
    logic              is_store;

    assign is_alu      = (opcode != 6'd0) && (opcode <= 6'd23);
    assign is_branch   = (opcode >= 6'd28);
    assign is_store    = opcode[0];
    assign state       = state_q;
    assign instr_count = count_q;

    // Moore decodes of state; the ready/branch_cond terms are the only input paths.
    always_comb begin
        imem_req       = 1'b0;
        ir_load        = 1'b0;
        pc_enable      = 1'b0;
        pc_load_branch = 1'b0;
        reg_write_en   = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        halted         = 1'b0;
        fault          = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_enable      = 1'b1;
                    pc_load_branch = branch_cond;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = is_store;
                pc_enable = dmem_ready && is_store;
            end
            S_WB: begin
                reg_write_en = 1'b1;
                pc_enable    = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            if (pc_enable) count_q <= count_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        wait_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready)               state_q <= S_DECODE;
                    else if (wait_q == WAIT_LAST) state_q <= S_FAULT;
                    else                          wait_q  <= wait_q + 1'b1;
                end
                S_DECODE: state_q <= (opcode == 6'd0) ? S_HALT : S_EXEC;
                S_EXEC: begin
                    wait_q <= '0;
                    if (is_branch)   state_q <= S_FETCH;
                    else if (is_alu) state_q <= S_WB;
                    else             state_q <= S_MEM;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_q <= is_store ? S_FETCH : S_WB;
                        wait_q  <= '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_FAULT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    wait_q  <= '0;
                end
                S_HALT:  state_q <= S_HALT;
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: builds expected per-cycle traces from instruction class
// and memory wait counts, then compares every DUT output each cycle.
module tb_cpu_sequencer;

    localparam int unsigned T  = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, imem_ready, dmem_ready, branch_cond;
    logic [5:0]    opcode;
    logic          imem_req, ir_load, pc_enable, pc_load_branch, reg_write_en;
    logic          dmem_req, dmem_we, halted, fault;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    cpu_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_cond(branch_cond),
        .imem_req(imem_req), .ir_load(ir_load), .pc_enable(pc_enable),
        .pc_load_branch(pc_load_branch), .reg_write_en(reg_write_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .halted(halted), .fault(fault),
        .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs that cycle must show.
    typedef struct packed {
        logic [2:0] st;
        logic [5:0] op;
        logic start, imem_rdy, dmem_rdy, bc;
        logic ireq, irl, pce, pcb, rwe, dreq, dwe, hlt, flt;
    } step_t;

    step_t         plan[$];
    step_t         cur;
    logic          chk_en = 1'b0;
    logic [CW-1:0] exp_cnt;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            chk("state", 32'(state), 32'(cur.st));
            chk("imem_req", 32'(imem_req), 32'(cur.ireq));
            chk("ir_load", 32'(ir_load), 32'(cur.irl));
            chk("pc_enable", 32'(pc_enable), 32'(cur.pce));
            chk("pc_load_branch", 32'(pc_load_branch), 32'(cur.pcb));
            chk("reg_write_en", 32'(reg_write_en), 32'(cur.rwe));
            chk("dmem_req", 32'(dmem_req), 32'(cur.dreq));
            chk("dmem_we", 32'(dmem_we), 32'(cur.dwe));
            chk("halted", 32'(halted), 32'(cur.hlt));
            chk("fault", 32'(fault), 32'(cur.flt));
            chk("instr_count", 32'(instr_count), 32'(exp_cnt));
            chk("rwe_dwe_excl", 32'(reg_write_en & dmem_we), 32'd0);
        end
    end

    function automatic step_t mk(input logic [2:0] st, input logic [5:0] op);
        step_t s;
        s     = '0;
        s.st  = st;
        s.op  = op;
        s.hlt = (st == 3'd6);
        s.flt = (st == 3'd7);
        return s;
    endfunction

    // Expected trace of one instruction: iw/dw = cycles the ready input stays low.
    task automatic build(input logic [5:0] op, input int unsigned iw,
                         input int unsigned dw, input logic bc);
        step_t s;
        for (int unsigned i = 0; i < ((iw < T) ? iw : T); i++) begin
            s = mk(3'd1, op); s.ireq = 1'b1; plan.push_back(s);
        end
        if (iw >= T) begin plan.push_back(mk(3'd7, op)); return; end
        s = mk(3'd1, op); s.ireq = 1'b1; s.imem_rdy = 1'b1; s.irl = 1'b1; plan.push_back(s);
        plan.push_back(mk(3'd2, op));
        if (op == 6'd0) begin plan.push_back(mk(3'd6, op)); return; end
        s = mk(3'd3, op); s.bc = bc;
        if (op >= 6'd28) begin s.pce = 1'b1; s.pcb = bc; plan.push_back(s); return; end
        plan.push_back(s);
        if (op >= 6'd24) begin
            for (int unsigned i = 0; i < ((dw < T) ? dw : T); i++) begin
                s = mk(3'd4, op); s.dreq = 1'b1; s.dwe = op[0]; plan.push_back(s);
            end
            if (dw >= T) begin plan.push_back(mk(3'd7, op)); return; end
            s = mk(3'd4, op); s.dreq = 1'b1; s.dwe = op[0]; s.dmem_rdy = 1'b1; s.pce = op[0];
            plan.push_back(s);
            if (op[0]) return;
        end
        s = mk(3'd5, op); s.rwe = 1'b1; s.pce = 1'b1; plan.push_back(s);
    endtask

    task automatic push_idle_start();
        step_t s;
        s = mk(3'd0, 6'd0); s.start = 1'b1; plan.push_back(s);
    endtask

    // limit=0 plays the whole plan; otherwise stops early and discards the rest.
    task automatic play(input int unsigned limit);
        int unsigned k;
        k = 0;
        while (plan.size() > 0 && (limit == 0 || k < limit)) begin
            cur         = plan.pop_front();
            start       = cur.start;
            opcode      = cur.op;
            imem_ready  = cur.imem_rdy;
            dmem_ready  = cur.dmem_rdy;
            branch_cond = cur.bc;
            chk_en      = 1'b1;
            @(posedge clk);
            if (cur.pce) exp_cnt = exp_cnt + 1'b1;
            #1;
            k++;
        end
        plan.delete();
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_cond = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt = '0;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        cur    = mk(3'd0, opcode);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0;
        step_t s;
        rst_n = 1'b0; start = 1'b0; opcode = '0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_cond = 1'b0;
        exp_cnt = '0;
        do_reset();

        // ALU, zero-wait: states 1,2,3,5 then back to FETCH
        push_idle_start();
        n0 = plan.size(); build(6'd5, 0, 0, 1'b0);
        chk("alu_latency", plan.size() - n0, 32'd4);
        play(0);
        chk("alu_count", 32'(instr_count), 32'd1);

        // load with dmem_ready delayed 3 cycles: 4 MEM cycles then WB
        build(6'd24, 0, 3, 1'b0);
        chk("load_len", plan.size(), 32'd8);
        play(0);
        chk("load_count", 32'(instr_count), 32'd2);

        build(6'd25, 0, 0, 1'b0);
        chk("store_latency", plan.size(), 32'd4);
        build(6'd30, 0, 0, 1'b1);
        build(6'd30, 0, 0, 1'b0);
        build(6'd28, 0, 0, 1'b1);
        build(6'd63, 0, 0, 1'b0);
        build(6'd23, 0, 0, 1'b0);
        build(6'd1, 2, 0, 1'b0);
        build(6'd27, 1, 2, 1'b0);
        build(6'd26, 0, 1, 1'b0);
        play(0);
        chk("mix_count", 32'(instr_count), 32'd11);

        // ready on the last permitted fetch wait cycle is accepted
        build(6'd5, T - 1, 0, 1'b0);
        chk("late_ready_len", plan.size(), 32'd19);
        play(0);

        // reset while waiting in MEM aborts the load
        build(6'd24, 0, 5, 1'b0);
        play(5);
        do_reset();

        // counter wrap: 260 branches through an 8-bit counter
        push_idle_start();
        for (int i = 0; i < 260; i++) build(6'd40, 0, 0, 1'(i));
        play(0);
        chk("wrap_count", 32'(instr_count), 32'd4);

        // fetch timeout: 16 cycles without imem_ready -> sticky FAULT
        build(6'd5, T, 0, 1'b0);
        chk("fetch_timeout_len", plan.size(), 32'd17);
        for (int i = 0; i < 3; i++) begin
            s = mk(3'd7, 6'd5); s.start = 1'b1; s.imem_rdy = 1'b1; s.dmem_rdy = 1'b1;
            plan.push_back(s);
        end
        play(0);
        chk("fault_sticky", 32'(fault), 32'd1);

        // data-memory timeout
        do_reset();
        push_idle_start();
        build(6'd25, 0, T, 1'b0);
        play(0);
        chk("dmem_fault", 32'(fault), 32'd1);

        // HALT two cycles after fetch, start pulses ignored, no pc_enable
        do_reset();
        push_idle_start();
        n0 = plan.size(); build(6'd0, 0, 0, 1'b0);
        chk("halt_latency", plan.size() - n0, 32'd3);
        for (int i = 0; i < 4; i++) begin
            s = mk(3'd6, 6'd0); s.start = 1'(i); s.imem_rdy = 1'b1; plan.push_back(s);
        end
        play(0);
        chk("halt_count", 32'(instr_count), 32'd0);
        chk("halted_held", 32'(halted), 32'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
